busdebugger_command_controller: RTL and testbench

Command sequencer and output arbiter for the serial bus debugger. Takes host command bytes from the USART receive path and drives the snooper's record_start/record_trigger and the dumper's dump_start. Arbitrates the single byte stream into the transmit async_fifo between controller response bytes and the dumper's record stream. Sits in the comm_clock domain between usart_rx, computie_bus_snooper, computie_bus_dumper and the tx fifo.

---
 rtl/busdebugger_command_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_busdebugger_command_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/busdebugger_command_controller.sv
// busdebugger_command_controller
// Host command sequencer and transmit-stream arbiter for the serial bus
// debugger. Decodes command bytes from usart_rx, pulses the snooper/dumper
// controls and multiplexes response bytes and the dumper's record stream into
// the single tx fifo byte stream. Runs entirely in the comm_clock domain.
// Optional build macro: DUMP_TIMEOUT_EN adds a dump watchdog that abandons a
// stalled dump after TIMEOUT_CYCLES cycles and answers 'T'.

module busdebugger_command_controller #(
    parameter int  DEPTH          = 32,
    parameter int  TIMEOUT_CYCLES = 65536,
    localparam int CNT_W          = $clog2(DEPTH) + 1
) (
    input  logic             comm_clock,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             record_start,
    output logic             record_trigger,
    input  logic             record_end,
    input  logic [CNT_W-1:0] record_count,
    output logic             dump_start,
    input  logic             dump_end,
    input  logic             dump_valid,
    input  logic [7:0]       dump_data,
    output logic             dump_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             led
);

    // Host command bytes
    localparam logic [7:0] CMD_RECORD  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_TRIGGER = 8'h74;  // 't'
    localparam logic [7:0] CMD_DUMP    = 8'h64;  // 'd'
    localparam logic [7:0] CMD_STATUS  = 8'h73;  // 's'

    // Response bytes
    localparam logic [7:0] RSP_OK      = 8'h6B;  // 'k'
    localparam logic [7:0] RSP_ERR     = 8'h21;  // '!'
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'
    localparam logic [7:0] RSP_DONE    = 8'h2E;  // '.'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

    // The status byte carries the record count, so it must fit in one byte.
    if (CNT_W > 8) begin : g_bad_depth
        $error("busdebugger_command_controller: record count width %0d exceeds 8 bits", CNT_W);
    end

    // The watchdog counter is 24 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16777215) begin : g_bad_timeout
        $error("busdebugger_command_controller: TIMEOUT_CYCLES %0d out of range", TIMEOUT_CYCLES);
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORDING,
        ST_DUMPING
    } state_t;

    state_t      state;
    logic        captured;     // a completed capture exists and may be dumped
    logic [7:0]  resp_byte0;   // byte currently offered on out_data
    logic [7:0]  resp_byte1;   // second byte of a two-byte status reply
    logic [1:0]  resp_len;     // bytes still pending in the response buffer

    state_t      eff_state;    // state as seen by a command this cycle
    logic        eff_captured;
    logic        cmd_accept;
    logic        resp_retire;
    logic        timeout_hit;

`ifdef DUMP_TIMEOUT_EN
    logic [23:0] wd_count;

    assign timeout_hit = (state == ST_DUMPING) && (wd_count == 24'(TIMEOUT_CYCLES));

    // Dump watchdog: restarts on entry to DUMPING and on every dumper byte handshake.
    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            wd_count <= '0;
        end else if (state != ST_DUMPING) begin
            wd_count <= '0;
        end else if (dump_valid && dump_ready) begin
            wd_count <= '0;
        end else if (!timeout_hit) begin
            wd_count <= wd_count + 24'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A capture finishing in the same cycle as a command is applied first, so
    // the command sees IDLE with a valid capture.
    always_comb begin
        eff_state    = state;
        eff_captured = captured;
        if (state == ST_RECORDING && record_end) begin
            eff_state    = ST_IDLE;
            eff_captured = 1'b1;
        end
    end

    // Handshakes, output arbitration and status flags.
    always_comb begin
        rx_ready    = (state != ST_DUMPING) && (resp_len == 2'd0);
        cmd_accept  = rx_valid && rx_ready;
        busy        = (state != ST_IDLE) || (resp_len != 2'd0);
        led         = (state == ST_RECORDING) || (state == ST_DUMPING);
        if (state == ST_DUMPING) begin
            // Once the watchdog fires the dumper's byte is neither passed on
            // nor accepted, so nothing is duplicated or lost on the tx side.
            out_valid   = dump_valid && !timeout_hit;
            out_data    = dump_data;
            dump_ready  = out_ready && !timeout_hit;
            resp_retire = 1'b0;
        end else begin
            out_valid   = (resp_len != 2'd0);
            out_data    = resp_byte0;
            dump_ready  = 1'b0;
            resp_retire = (resp_len != 2'd0) && out_ready;
        end
    end

    // Command FSM: registered control pulses and the response buffer.
    // NOTE: reset is asynchronous and every register here is cleared by it, so
    // an abort mid-dump or mid-response drops pending bytes at once.
    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            captured       <= 1'b0;
            resp_byte0     <= 8'h00;
            resp_byte1     <= 8'h00;
            resp_len       <= 2'd0;
            record_start   <= 1'b0;
            record_trigger <= 1'b0;
            dump_start     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block
            // override earlier ones, which gives commands priority over the
            // record_end default without any ordering hazards.
            record_start   <= 1'b0;
            record_trigger <= 1'b0;
            dump_start     <= 1'b0;

            if (resp_retire) begin
                resp_byte0 <= resp_byte1;
                resp_byte1 <= 8'h00;
                resp_len   <= resp_len - 2'd1;
            end

            case (state)
                ST_RECORDING: begin
                    if (record_end) begin
                        state    <= ST_IDLE;
                        captured <= 1'b1;
                    end
                end
                ST_DUMPING: begin
                    if (dump_end) begin
                        state      <= ST_IDLE;
                        resp_byte0 <= RSP_DONE;
                        resp_byte1 <= 8'h00;
                        resp_len   <= 2'd1;
                    end else if (timeout_hit) begin
                        state      <= ST_IDLE;
                        resp_byte0 <= RSP_TIMEOUT;
                        resp_byte1 <= 8'h00;
                        resp_len   <= 2'd1;
                    end
                end
                default: ;
            endcase

            // Commands are only accepted with an empty buffer outside DUMPING,
            // so they never collide with a retire or a dump completion.
            if (cmd_accept) begin
                resp_byte1 <= 8'h00;
                resp_len   <= 2'd1;
                case (rx_data)
                    CMD_RECORD: begin
                        if (eff_state == ST_IDLE) begin
                            record_start <= 1'b1;
                            captured     <= 1'b0;
                            state        <= ST_RECORDING;
                            resp_byte0   <= RSP_OK;
                        end else begin
                            resp_byte0   <= RSP_ERR;
                        end
                    end
                    CMD_TRIGGER: begin
                        if (eff_state == ST_RECORDING) begin
                            record_trigger <= 1'b1;
                            resp_byte0     <= RSP_OK;
                        end else begin
                            resp_byte0     <= RSP_ERR;
                        end
                    end
                    CMD_DUMP: begin
                        if (eff_state == ST_IDLE && eff_captured) begin
                            dump_start <= 1'b1;
                            state      <= ST_DUMPING;
                            resp_len   <= 2'd0;
                        end else begin
                            resp_byte0 <= RSP_ERR;
                        end
                    end
                    CMD_STATUS: begin
                        resp_byte0 <= {6'b0, eff_captured, eff_state == ST_RECORDING};
                        resp_byte1 <= 8'(record_count);
                        resp_len   <= 2'd2;
                    end
                    default: begin
                        resp_byte0 <= RSP_UNKNOWN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_busdebugger_command_controller.sv
// Directed testbench for busdebugger_command_controller. The bench plays host,
// snooper, dumper and tx fifo. Build with DUMP_TIMEOUT_EN defined to exercise
// the dump watchdog (instantiated with TIMEOUT_CYCLES = 16).

module tb_busdebugger_command_controller;

    localparam int DEPTH = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             comm_clock = 1'b0;
    logic             reset      = 1'b1;
    logic             rx_valid   = 1'b0;
    logic [7:0]       rx_data    = 8'h00;
    logic             rx_ready;
    logic             record_start;
    logic             record_trigger;
    logic             record_end   = 1'b0;
    logic [CNT_W-1:0] record_count = '0;
    logic             dump_start;
    logic             dump_end     = 1'b0;
    logic             dump_valid   = 1'b0;
    logic [7:0]       dump_data    = 8'h00;
    logic             dump_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready    = 1'b0;
    logic             busy;
    logic             led;

    int total = 0;
    int bad   = 0;

    busdebugger_command_controller #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .comm_clock     (comm_clock),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .record_start   (record_start),
        .record_trigger (record_trigger),
        .record_end     (record_end),
        .record_count   (record_count),
        .dump_start     (dump_start),
        .dump_end       (dump_end),
        .dump_valid     (dump_valid),
        .dump_data      (dump_data),
        .dump_ready     (dump_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .busy           (busy),
        .led            (led)
    );

    always #5 comm_clock = ~comm_clock;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge comm_clock);
        #1;
    endtask

    // Present a command byte; returns #1 after the accepting edge (cycle N+1).
    task automatic send_cmd(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            step();
            n++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_cmd_%h: rx_ready never rose got=%b want=1", b, rx_ready);
        end
        step();
        rx_valid = 1'b0;
    endtask

    // Collect one tx byte with out_ready held high; bounded wait.
    task automatic get_byte(output logic [7:0] b, output bit ok);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        ok = out_valid;
        b  = out_data;
        if (ok) step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL rst_out_valid: got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00)      begin bad++; $display("FAIL rst_out_data: got=%h want=00", out_data); end
        total++; if (busy !== 1'b0 || led !== 1'b0) begin bad++; $display("FAIL rst_busy_led: got=%b%b want=00", busy, led); end
        total++; if ({record_start, record_trigger, dump_start, dump_ready} !== 4'b0000)
            begin bad++; $display("FAIL rst_pulses: got=%b want=0000", {record_start, record_trigger, dump_start, dump_ready}); end
        reset = 1'b0;
        step();
        total++; if (rx_ready !== 1'b1)       begin bad++; $display("FAIL rst_rx_ready: got=%b want=1", rx_ready); end
    endtask

    task automatic test_errors();
        logic [7:0] b;
        bit ok;
        send_cmd(8'h64);
        total++; if (dump_start !== 1'b0) begin bad++; $display("FAIL err_d_no_start: got=%b want=0", dump_start); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h21) begin bad++; $display("FAIL err_d_resp: got=%h ok=%b want=21", b, ok); end
        send_cmd(8'h55);
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h3F) begin bad++; $display("FAIL err_unknown_resp: got=%h ok=%b want=3f", b, ok); end
        send_cmd(8'h74);
        total++; if (record_trigger !== 1'b0) begin bad++; $display("FAIL err_t_no_trig: got=%b want=0", record_trigger); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h21) begin bad++; $display("FAIL err_t_resp: got=%h ok=%b want=21", b, ok); end
    endtask

    task automatic test_status_idle();
        logic [7:0] b;
        bit ok;
        send_cmd(8'h73);
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL stat_rx_ready_0: got=%b want=0", rx_ready); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h00) begin bad++; $display("FAIL stat_byte0: got=%h ok=%b want=00", b, ok); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL stat_rx_ready_1: got=%b want=0", rx_ready); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h00) begin bad++; $display("FAIL stat_byte1: got=%h ok=%b want=00", b, ok); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL stat_rx_ready_2: got=%b want=1", rx_ready); end
    endtask

    task automatic test_record();
        logic [7:0] b;
        bit ok;
        send_cmd(8'h72);
        total++; if (record_start !== 1'b1) begin bad++; $display("FAIL rec_start_pulse: got=%b want=1", record_start); end
        total++; if (led !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rec_led_busy: got=%b%b want=11", led, busy); end
        total++; if (out_valid !== 1'b1 || out_data !== 8'h6B) begin bad++; $display("FAIL rec_resp_n1: got=%b/%h want=1/6b", out_valid, out_data); end
        step();
        total++; if (record_start !== 1'b0) begin bad++; $display("FAIL rec_start_width: got=%b want=0", record_start); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h6B) begin bad++; $display("FAIL rec_resp: got=%h ok=%b want=6b", b, ok); end
        send_cmd(8'h72);
        total++; if (record_start !== 1'b0) begin bad++; $display("FAIL rec_again_no_start: got=%b want=0", record_start); end
        repeat (3) step();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin bad++; $display("FAIL rec_again_hold: got=%b/%h want=1/21", out_valid, out_data); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h21) begin bad++; $display("FAIL rec_again_resp: got=%h ok=%b want=21", b, ok); end
    endtask

    task automatic test_trigger();
        logic [7:0] b;
        bit ok;
        send_cmd(8'h74);
        total++; if (record_trigger !== 1'b1) begin bad++; $display("FAIL trig_pulse: got=%b want=1", record_trigger); end
        step();
        total++; if (record_trigger !== 1'b0) begin bad++; $display("FAIL trig_width: got=%b want=0", record_trigger); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h6B) begin bad++; $display("FAIL trig_resp: got=%h ok=%b want=6b", b, ok); end
        record_count = CNT_W'(5);
        record_end   = 1'b1;
        step();
        record_end   = 1'b0;
        total++; if (led !== 1'b0) begin bad++; $display("FAIL trig_end_led: got=%b want=0", led); end
        send_cmd(8'h73);
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h02) begin bad++; $display("FAIL trig_stat0: got=%h ok=%b want=02", b, ok); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h05) begin bad++; $display("FAIL trig_stat1: got=%h ok=%b want=05", b, ok); end
    endtask

    task automatic test_dump();
        logic [7:0] exp_bytes [3];
        logic [7:0] got_bytes [3];
        logic [7:0] b;
        bit ok;
        int idx = 0;
        int pass_err = 0;
        exp_bytes[0] = 8'hA1;
        exp_bytes[1] = 8'hB2;
        exp_bytes[2] = 8'hC3;
        send_cmd(8'h64);
        total++; if (dump_start !== 1'b1 || led !== 1'b1) begin bad++; $display("FAIL dump_start_pulse: got=%b led=%b want=1/1", dump_start, led); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dump_no_resp: got=%b want=0", out_valid); end
        step();
        total++; if (dump_start !== 1'b0) begin bad++; $display("FAIL dump_start_width: got=%b want=0", dump_start); end
        for (int cyc = 0; cyc < 30 && idx < 3; cyc++) begin
            dump_valid = 1'b1;
            dump_data  = exp_bytes[idx];
            out_ready  = cyc[0];
            #1;
            if (out_valid !== 1'b1 || out_data !== dump_data || dump_ready !== out_ready) pass_err++;
            if (out_ready) begin
                got_bytes[idx] = out_data;
                idx++;
            end
            step();
        end
        dump_valid = 1'b0;
        out_ready  = 1'b0;
        #1;
        total++; if (pass_err != 0 || idx != 3) begin bad++; $display("FAIL dump_passthru: errors=%0d bytes=%0d want=0/3", pass_err, idx); end
        for (int i = 0; i < 3; i++) begin
            total++; if (got_bytes[i] !== exp_bytes[i]) begin bad++; $display("FAIL dump_byte%0d: got=%h want=%h", i, got_bytes[i], exp_bytes[i]); end
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dump_idle_valid: got=%b want=0", out_valid); end
        dump_end = 1'b1;
        step();
        dump_end = 1'b0;
        total++; if (led !== 1'b0) begin bad++; $display("FAIL dump_end_led: got=%b want=0", led); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h2E) begin bad++; $display("FAIL dump_end_resp: got=%h ok=%b want=2e", b, ok); end
    endtask

    task automatic test_same_cycle();
        logic [7:0] b;
        bit ok;
        send_cmd(8'h72);
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h6B) begin bad++; $display("FAIL same_rec_resp: got=%h ok=%b want=6b", b, ok); end
        rx_valid   = 1'b1;
        rx_data    = 8'h74;
        record_end = 1'b1;
        step();
        rx_valid   = 1'b0;
        record_end = 1'b0;
        total++; if (record_trigger !== 1'b0 || led !== 1'b0) begin bad++; $display("FAIL same_trig_led: got=%b%b want=00", record_trigger, led); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h21) begin bad++; $display("FAIL same_resp: got=%h ok=%b want=21", b, ok); end
        send_cmd(8'h73);
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h02) begin bad++; $display("FAIL same_stat0: got=%h ok=%b want=02", b, ok); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h05) begin bad++; $display("FAIL same_stat1: got=%h ok=%b want=05", b, ok); end
    endtask

    task automatic test_stall();
        logic [7:0] b;
        bit ok;
        send_cmd(8'h64);
        total++; if (dump_start !== 1'b1) begin bad++; $display("FAIL stall_redump: got=%b want=1", dump_start); end
`ifdef DUMP_TIMEOUT_EN
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h54) begin bad++; $display("FAIL stall_timeout_resp: got=%h ok=%b want=54", b, ok); end
        total++; if (led !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_timeout_idle: got=%b%b want=00", led, busy); end
`else
        repeat (40) step();
        total++; if (led !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_waiting: got=%b%b%b want=110", led, busy, out_valid); end
        dump_end = 1'b1;
        step();
        dump_end = 1'b0;
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h2E) begin bad++; $display("FAIL stall_end_resp: got=%h ok=%b want=2e", b, ok); end
`endif
    endtask

    task automatic test_reset_mid_dump();
        logic [7:0] b;
        bit ok;
        send_cmd(8'h64);
        dump_valid = 1'b1;
        dump_data  = 8'h99;
        out_ready  = 1'b1;
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h99) begin bad++; $display("FAIL mid_passthru: got=%b/%h want=1/99", out_valid, out_data); end
        reset = 1'b1;
        #1;
        total++; if ({out_valid, dump_ready, dump_start, led, busy} !== 5'b00000)
            begin bad++; $display("FAIL mid_async_clear: got=%b want=00000", {out_valid, dump_ready, dump_start, led, busy}); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL mid_out_data: got=%h want=00", out_data); end
        dump_valid = 1'b0;
        out_ready  = 1'b0;
        step();
        reset = 1'b0;
        step();
        send_cmd(8'h64);
        total++; if (dump_start !== 1'b0) begin bad++; $display("FAIL mid_captured_cleared: got=%b want=0", dump_start); end
        get_byte(b, ok);
        total++; if (!ok || b !== 8'h21) begin bad++; $display("FAIL mid_post_resp: got=%h ok=%b want=21", b, ok); end
    endtask

    initial begin
        test_reset();
        test_errors();
        test_status_idle();
        test_record();
        test_trigger();
        test_dump();
        test_same_cycle();
        test_stall();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
